// File: rtl/keycode_pkg.sv
// keycode_pkg: shared types and constants for the PS/2 keycode mailbox.
//   - parser state enum, PS/2 prefix/status byte values
//   - bit positions of the keycode status word and the keycode_reset controls
//   - FIFO entry struct and a count-saturation helper
package keycode_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned SEQ_W  = 8;
    localparam int unsigned SKIP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } parse_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;

    // keycode status word layout
    localparam int unsigned KC_VALID    = 31;
    localparam int unsigned KC_OVF      = 30;
    localparam int unsigned KC_CNT_LSB  = 27;
    localparam int unsigned KC_SEQ_LSB  = 16;
    localparam int unsigned KC_EXT      = 9;
    localparam int unsigned KC_BRK      = 8;
    localparam int unsigned KC_CODE_LSB = 0;

    // keycode_reset control bits
    localparam int unsigned KR_POP   = 0;
    localparam int unsigned KR_CLR   = 1;
    localparam int unsigned KR_FLUSH = 2;

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } entry_t;

    // Count field is 3 bits wide and saturates at 7.
    function automatic logic [2:0] sat_count(input logic [3:0] c);
        return (c > 4'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/keycode_fifo.sv
// keycode_fifo: synchronous FIFO of keycode entries.
//   clk, reset     : clock, synchronous active-high reset
//   push, wr_entry : write request and data
//   pop            : drop head entry (ignored when empty)
//   flush          : empty the FIFO; overrides push and pop
//   head_c         : head entry (meaningful only when count != 0)
//   count          : number of stored entries
//   push_ok_c      : push is accepted this cycle
module keycode_fifo
    import keycode_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  entry_t           wr_entry,
    input  logic             pop,
    input  logic             flush,
    output entry_t           head_c,
    output logic [CNT_W-1:0] count,
    output logic             push_ok_c
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop_ok_c;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign pop_ok_c  = pop & ~flush & (count != '0);
    assign push_ok_c = push & ~flush & ((count != CNT_W'(DEPTH)) | pop_ok_c);
    assign head_c    = mem[rd_ptr];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keycode_mailbox.sv
// keycode_mailbox: PS/2 byte stream -> make/break event FIFO -> HPS status word.
//   clk_clk        : system clock
//   reset_reset    : synchronous active-high reset
//   ps2_byte       : received PS/2 byte, qualified by ps2_byte_valid
//   ps2_byte_valid : one-cycle byte strobe
//   keycode_reset  : HPS control word; rising edges of bit0 pop, bit1 clear overflow, bit2 flush
//   keycode        : status word {valid, overflow, count, seq, ext, brk, code}
//   fifo_full      : FIFO holds DEPTH entries
module keycode_mailbox
    import keycode_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned FILTER_REPEAT = 1,
    parameter int unsigned E1_SKIP       = 7
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [7:0]  ps2_byte,
    input  logic        ps2_byte_valid,
    input  logic [31:0] keycode_reset,
    output logic [31:0] keycode,
    output logic        fifo_full
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = AW + 1;

    parse_state_e       state;
    logic [SKIP_W-1:0]  skip_cnt;
    logic               last_v;
    logic               last_ext;
    logic [CODE_W-1:0]  last_code;
    logic               emit_v;
    logic               emit_ext;
    logic               emit_brk;
    logic [CODE_W-1:0]  emit_code;

    logic               is_ext_c;
    logic               is_brk_c;
    logic               cand_v_c;
    logic               cand_ext_c;
    logic               cand_brk_c;
    logic               drop_c;

    logic [2:0]         sw_q;
    logic               pop_p;
    logic               clr_p;
    logic               flush_p;
    logic               unused_sw_bits;

    logic [SEQ_W-1:0]   seq;
    logic               overflow;
    entry_t             wr_entry_c;
    entry_t             head_c;
    logic [CNT_W-1:0]   fifo_count;
    logic               push_ok_c;
    logic [31:0]        kc_next_c;

    assign is_ext_c       = (ps2_byte == PS2_EXT);
    assign is_brk_c       = (ps2_byte == PS2_BRK);
    assign unused_sw_bits = ^keycode_reset[31:3];

    // Classify the current byte: does it complete an event, and of which kind.
    always_comb begin
        cand_v_c   = 1'b0;
        cand_ext_c = 1'b0;
        cand_brk_c = 1'b0;
        if (ps2_byte_valid) begin
            case (state)
                IDLE: begin
                    cand_v_c = ~is_ext_c & ~is_brk_c & (ps2_byte != PS2_PAUSE) &
                               (ps2_byte != PS2_BAT) & (ps2_byte != PS2_ACK);
                end
                EXT: begin
                    cand_v_c   = ~is_ext_c & ~is_brk_c;
                    cand_ext_c = 1'b1;
                end
                BRK: begin
                    cand_v_c   = ~is_ext_c & ~is_brk_c;
                    cand_brk_c = 1'b1;
                end
                EXT_BRK: begin
                    cand_v_c   = ~is_ext_c & ~is_brk_c;
                    cand_ext_c = 1'b1;
                    cand_brk_c = 1'b1;
                end
                default: begin
                end
            endcase
        end
        // Typematic repeat: same make as the last one with no break between.
        drop_c = (FILTER_REPEAT != 0) & cand_v_c & ~cand_brk_c & last_v &
                 (last_ext == cand_ext_c) & (last_code == ps2_byte);
    end

    // Parser FSM, repeat-filter memory and registered emit.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            last_v    <= 1'b0;
            last_ext  <= 1'b0;
            last_code <= '0;
            emit_v    <= 1'b0;
            emit_ext  <= 1'b0;
            emit_brk  <= 1'b0;
            emit_code <= '0;
        end else begin
            emit_v <= cand_v_c & ~drop_c;
            if (cand_v_c) begin
                emit_ext  <= cand_ext_c;
                emit_brk  <= cand_brk_c;
                emit_code <= ps2_byte;
                if (cand_brk_c) begin
                    last_v <= 1'b0;
                end else begin
                    last_v    <= 1'b1;
                    last_ext  <= cand_ext_c;
                    last_code <= ps2_byte;
                end
            end
            if (ps2_byte_valid) begin
                case (state)
                    IDLE: begin
                        if (is_ext_c) begin
                            state <= EXT;
                        end else if (is_brk_c) begin
                            state <= BRK;
                        end else if ((ps2_byte == PS2_PAUSE) && (E1_SKIP != 0)) begin
                            state    <= SKIP;
                            skip_cnt <= SKIP_W'(E1_SKIP);
                        end
                    end
                    EXT: begin
                        if (is_brk_c) begin
                            state <= EXT_BRK;
                        end else if (!is_ext_c) begin
                            state <= IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        state <= IDLE;
                    end
                    SKIP: begin
                        skip_cnt <= skip_cnt - SKIP_W'(1);
                        if (skip_cnt <= SKIP_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Rising-edge detect on the software control bits.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sw_q    <= '0;
            pop_p   <= 1'b0;
            clr_p   <= 1'b0;
            flush_p <= 1'b0;
        end else begin
            sw_q    <= keycode_reset[2:0];
            pop_p   <= keycode_reset[KR_POP]   & ~sw_q[KR_POP];
            clr_p   <= keycode_reset[KR_CLR]   & ~sw_q[KR_CLR];
            flush_p <= keycode_reset[KR_FLUSH] & ~sw_q[KR_FLUSH];
        end
    end

    always_comb begin
        wr_entry_c      = '0;
        wr_entry_c.seq  = seq;
        wr_entry_c.ext  = emit_ext;
        wr_entry_c.brk  = emit_brk;
        wr_entry_c.code = emit_code;
    end

    keycode_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (emit_v),
        .wr_entry  (wr_entry_c),
        .pop       (pop_p),
        .flush     (flush_p),
        .head_c    (head_c),
        .count     (fifo_count),
        .push_ok_c (push_ok_c)
    );

    // Sequence stamp and sticky overflow; a flushed push is not an overflow.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                seq <= seq + SEQ_W'(1);
            end
            overflow <= (overflow & ~clr_p) | (emit_v & ~flush_p & ~push_ok_c);
        end
    end

    // Status word assembly; entry fields read as zero when empty.
    always_comb begin
        kc_next_c                        = '0;
        kc_next_c[KC_OVF]                = overflow;
        kc_next_c[KC_CNT_LSB +: 3]       = sat_count(4'(fifo_count));
        if (fifo_count != '0) begin
            kc_next_c[KC_VALID]              = 1'b1;
            kc_next_c[KC_SEQ_LSB +: SEQ_W]   = head_c.seq;
            kc_next_c[KC_EXT]                = head_c.ext;
            kc_next_c[KC_BRK]                = head_c.brk;
            kc_next_c[KC_CODE_LSB +: CODE_W] = head_c.code;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            keycode   <= '0;
            fifo_full <= 1'b0;
        end else begin
            keycode   <= kc_next_c;
            fifo_full <= (fifo_count == CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_keycode_mailbox.sv
// tb_keycode_mailbox: directed vector table, hand-written corner sequences and
// randomized byte/control stimulus checked against a queue-based reference model.
module tb_keycode_mailbox;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic [7:0]  ps2_byte;
    logic        ps2_byte_valid;
    logic [31:0] keycode_reset;
    logic [31:0] keycode;
    logic        fifo_full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keycode_mailbox #(
        .DEPTH         (4),
        .FILTER_REPEAT (1),
        .E1_SKIP       (7)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (reset_reset),
        .ps2_byte       (ps2_byte),
        .ps2_byte_valid (ps2_byte_valid),
        .keycode_reset  (keycode_reset),
        .keycode        (keycode),
        .fifo_full      (fifo_full)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] seq;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ment_t;

    ment_t      mq[$];
    logic [7:0] m_prefix[$];
    bit         m_ovf;
    int         m_seq;
    bit         m_last_v;
    logic [8:0] m_last;
    int         m_skip;

    function automatic void model_reset();
        mq.delete();
        m_prefix.delete();
        m_ovf    = 0;
        m_seq    = 0;
        m_last_v = 0;
        m_last   = '0;
        m_skip   = 0;
    endfunction

    function automatic void model_event(bit ext, bit brk, logic [7:0] code);
        ment_t e;
        if (!brk) begin
            if (m_last_v && m_last == {ext, code}) return;
            m_last_v = 1;
            m_last   = {ext, code};
        end else begin
            m_last_v = 0;
        end
        if (mq.size() >= 4) begin
            m_ovf = 1;
        end else begin
            e.seq  = 8'(m_seq);
            e.ext  = ext;
            e.brk  = brk;
            e.code = code;
            mq.push_back(e);
            m_seq = (m_seq + 1) % 256;
        end
    endfunction

    // Prefix bytes accumulate; the first non-prefix byte closes the event.
    function automatic void model_byte(logic [7:0] b);
        bit ext;
        bit brk;
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        if (m_prefix.size() == 0) begin
            if (b == 8'hE1) begin
                m_skip = 7;
                return;
            end
            if (b == 8'hAA || b == 8'hFA) return;
        end
        if (b == 8'hE0) begin
            if (m_prefix.size() == 0 || (m_prefix.size() == 1 && m_prefix[0] == 8'hE0)) begin
                m_prefix.delete();
                m_prefix.push_back(8'hE0);
            end else begin
                m_prefix.delete();
            end
            return;
        end
        if (b == 8'hF0) begin
            if (m_prefix.size() == 0 || (m_prefix.size() == 1 && m_prefix[0] == 8'hE0))
                m_prefix.push_back(8'hF0);
            else
                m_prefix.delete();
            return;
        end
        ext = 0;
        brk = 0;
        foreach (m_prefix[i]) begin
            if (m_prefix[i] == 8'hE0) ext = 1;
            if (m_prefix[i] == 8'hF0) brk = 1;
        end
        m_prefix.delete();
        model_event(ext, brk, b);
    endfunction

    function automatic void model_sw(logic [2:0] bits);
        if (bits[2]) mq.delete();
        else if (bits[0] && mq.size() > 0) void'(mq.pop_front());
        if (bits[1]) m_ovf = 0;
    endfunction

    function automatic logic [31:0] model_kc();
        logic [31:0] r;
        int n;
        r     = '0;
        r[30] = m_ovf;
        if (mq.size() > 0) begin
            n          = (mq.size() > 7) ? 7 : mq.size();
            r[31]      = 1'b1;
            r[29:27]   = 3'(n);
            r[23:16]   = mq[0].seq;
            r[9]       = mq[0].ext;
            r[8]       = mq[0].brk;
            r[7:0]     = mq[0].code;
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_reset    = 1'b1;
        ps2_byte_valid = 1'b0;
        keycode_reset  = '0;
        @(negedge clk);
        @(negedge clk);
        reset_reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ps2_byte       = b;
        ps2_byte_valid = 1'b1;
        @(negedge clk);
        ps2_byte_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic sw_pulse(input logic [2:0] bits);
        @(negedge clk);
        keycode_reset = {29'b0, bits};
        @(negedge clk);
        keycode_reset = '0;
        model_sw(bits);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          n;
        logic [7:0]  b [4];
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1,
                                logic [7:0] b2, logic [7:0] b3, logic [31:0] exp);
        vec_t v;
        v.n    = n;
        v.b[0] = b0;
        v.b[1] = b1;
        v.b[2] = b2;
        v.b[3] = b3;
        v.exp  = exp;
        return v;
    endfunction

    vec_t tv[12];
    logic [7:0] pool[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [2:0] bits;
        int r;

        reset_reset    = 1'b1;
        ps2_byte       = '0;
        ps2_byte_valid = 1'b0;
        keycode_reset  = '0;

        tv[0]  = mk(1, 8'h1C, 8'h00, 8'h00, 8'h00, 32'h8800_001C);
        tv[1]  = mk(2, 8'hF0, 8'h1C, 8'h00, 8'h00, 32'h8800_011C);
        tv[2]  = mk(2, 8'hE0, 8'h75, 8'h00, 8'h00, 32'h8800_0275);
        tv[3]  = mk(3, 8'hE0, 8'hF0, 8'h75, 8'h00, 32'h8800_0375);
        tv[4]  = mk(1, 8'hAA, 8'h00, 8'h00, 8'h00, 32'h0000_0000);
        tv[5]  = mk(1, 8'hFA, 8'h00, 8'h00, 8'h00, 32'h0000_0000);
        tv[6]  = mk(2, 8'hF0, 8'hE0, 8'h00, 8'h00, 32'h0000_0000);
        tv[7]  = mk(3, 8'hE0, 8'hE0, 8'h6B, 8'h00, 32'h8800_026B);
        tv[8]  = mk(3, 8'hE0, 8'hF0, 8'hF0, 8'h00, 32'h0000_0000);
        tv[9]  = mk(3, 8'hF0, 8'hE0, 8'h1C, 8'h00, 32'h8800_001C);
        tv[10] = mk(2, 8'hE0, 8'hAA, 8'h00, 8'h00, 32'h8800_02AA);
        tv[11] = mk(2, 8'hE1, 8'h1C, 8'h00, 8'h00, 32'h0000_0000);

        pool = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h1C,
                 8'h75, 8'h29, 8'h32, 8'h6B, 8'h5A, 8'h15};

        // Reset state
        do_reset();
        @(posedge clk);
        #1;
        check("reset_keycode", keycode, 32'h0);
        check("reset_full", {31'b0, fifo_full}, 32'h0);

        // Single make: exact latency, then break, then pop
        send(8'h1C);
        @(posedge clk);
        #1;
        check("lat_edge_k1", keycode, 32'h0);
        @(posedge clk);
        #1;
        check("lat_edge_k2", keycode, 32'h8800_001C);
        send(8'hF0);
        send(8'h1C);
        settle();
        check("two_entries", keycode, 32'h9000_001C);
        sw_pulse(3'b001);
        settle();
        check("pop_head_brk", keycode, 32'h8801_011C);

        // Pause sequence swallowed, seq advances by one only
        do_reset();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        settle();
        check("pause_no_entry", keycode, 32'h0);
        send(8'h29);
        settle();
        check("pause_then_29", keycode, 32'h8800_0029);
        send(8'h1C);
        settle();
        sw_pulse(3'b001);
        settle();
        check("pause_seq_next", keycode, 32'h8801_001C);

        // Typematic repeat filter
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C);
        settle();
        check("repeat_one", keycode, 32'h8800_001C);
        send(8'hF0); send(8'h1C); send(8'h1C);
        settle();
        check("repeat_after_brk", keycode, 32'h9800_001C);
        sw_pulse(3'b001);
        settle();
        check("repeat_pop1", keycode, 32'h9001_011C);
        sw_pulse(3'b001);
        settle();
        check("repeat_pop2", keycode, 32'h8802_001C);

        // Overflow and clear
        do_reset();
        send(8'h15); send(8'h1D); send(8'h24);
        send(8'h2D); send(8'h2C); send(8'h35);
        settle();
        check("ovf_keycode", keycode, 32'hE000_0015);
        check("ovf_full", {31'b0, fifo_full}, 32'h1);
        sw_pulse(3'b010);
        settle();
        check("ovf_cleared", keycode, 32'hA000_0015);
        check("ovf_still_full", {31'b0, fifo_full}, 32'h1);

        // Push and pop in the same cycle while full
        @(negedge clk);
        keycode_reset  = 32'h1;
        ps2_byte       = 8'h43;
        ps2_byte_valid = 1'b1;
        @(negedge clk);
        keycode_reset  = '0;
        ps2_byte_valid = 1'b0;
        settle();
        check("pushpop_full", keycode, 32'hA001_001D);
        check("pushpop_still_full", {31'b0, fifo_full}, 32'h1);

        // Flush together with a push: flush wins, no overflow
        @(negedge clk);
        keycode_reset  = 32'h4;
        ps2_byte       = 8'h4B;
        ps2_byte_valid = 1'b1;
        @(negedge clk);
        keycode_reset  = '0;
        ps2_byte_valid = 1'b0;
        settle();
        check("flush_push", keycode, 32'h0);
        check("flush_not_full", {31'b0, fifo_full}, 32'h0);
        send(8'h4D);
        settle();
        check("after_flush_seq", keycode, 32'h8805_004D);

        // Reset in the middle of an extended break
        do_reset();
        send(8'hE0);
        send(8'hF0);
        do_reset();
        send(8'h75);
        settle();
        check("reset_mid_seq", keycode, 32'h8800_0075);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            do_reset();
            for (int j = 0; j < tv[i].n; j++) send(tv[i].b[j]);
            settle();
            check($sformatf("vec[%0d]", i), keycode, tv[i].exp);
        end

        // Randomized stimulus against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)       bits = 3'b001;
                else if (r < 8)  bits = 3'b010;
                else if (r == 8) bits = 3'b100;
                else             bits = 3'b101;
                sw_pulse(bits);
            end else begin
                if ($urandom_range(0, 7) == 0) b = 8'($urandom);
                else                           b = pool[$urandom_range(0, 11)];
                send(b);
            end
            settle();
            check($sformatf("rand_kc[%0d]", i), keycode, model_kc());
            check($sformatf("rand_full[%0d]", i), {31'b0, fifo_full},
                  {31'b0, (mq.size() == 4)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
